// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response handshake bundle between decode, alu_seq and writeback
interface alu_seq_if #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic             use_imm;
  logic [XLEN-1:0]  src_a;
  logic [XLEN-1:0]  src_b;
  logic [IMM_W-1:0] imm;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic             illegal;
  logic             busy;
  modport master (
    output in_valid, op, use_imm, src_a, src_b, imm, out_ready,
    input  in_ready, out_valid, result, illegal, busy
  );
  modport slave (
    input  in_valid, op, use_imm, src_a, src_b, imm, out_ready,
    output in_ready, out_valid, result, illegal, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked execution unit, single-cycle ALU ops plus iterative mul/div
module alu_seq #(
  parameter int XLEN          = 32,
  parameter int IMM_W         = 12,
  parameter int ENABLE_MULDIV = 1
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  localparam int SW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [4:0]      op;
  logic [XLEN-1:0] a, b, ma, mb, alu_res, quick_res;
  logic [SW-1:0]   sh;
  logic            bad, is_md, is_div, sa, sb, div_zero, div_ovf, quick, accept;
  logic [4:0]      op_r;
  logic [5:0]      cnt;
  logic [XLEN-1:0] hi, lo, bm, nxt_hi, nxt_lo, quo, rem, eng_res, result_r;
  logic            neg_q, neg_r, illegal_r, mul_r, fits, last;
  logic [XLEN:0]   sum, trial;
  logic [2*XLEN-1:0] prod, prod_s;
  assign op = bus.op;
  assign a  = bus.src_a;
  assign b  = bus.use_imm ? {{(XLEN-IMM_W){bus.imm[IMM_W-1]}}, bus.imm} : bus.src_b;
  assign sh = b[SW-1:0];
  assign accept = bus.in_valid && state == IDLE;
  assign bad      = op > 5'd17 || (ENABLE_MULDIV == 0 && op >= 5'd10);
  assign is_md    = !bad && op >= 5'd10;
  assign is_div   = is_md && op >= 5'd14;
  assign sa       = (op == 5'd10 || op == 5'd11 || op == 5'd12 || op == 5'd14 || op == 5'd16) && a[XLEN-1];
  assign sb       = (op == 5'd10 || op == 5'd11 || op == 5'd14 || op == 5'd16) && b[XLEN-1];
  assign div_zero = is_div && b == '0;
  assign div_ovf  = is_div && (op == 5'd14 || op == 5'd16) && a == {1'b1, {(XLEN-1){1'b0}}} && (&b);
  assign quick    = !is_md || div_zero || div_ovf;
  assign ma       = sa ? -a : a;
  assign mb       = sb ? -b : b;
  assign quick_res = bad ? '0 :
                     div_zero ? ((op == 5'd14 || op == 5'd15) ? '1 : a) :
                     div_ovf ? (op == 5'd14 ? a : '0) : alu_res;
  // single-cycle arithmetic, logic and shift results
  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:    alu_res = a + b;
      5'd1:    alu_res = a - b;
      5'd2:    alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      5'd3:    alu_res = {{(XLEN-1){1'b0}}, a < b};
      5'd4:    alu_res = a & b;
      5'd5:    alu_res = a | b;
      5'd6:    alu_res = a ^ b;
      5'd7:    alu_res = a << sh;
      5'd8:    alu_res = a >> sh;
      5'd9:    alu_res = XLEN'($signed(a) >>> sh);
      default: alu_res = '0;
    endcase
  end
  // one engine step: shift-add multiply on {hi,lo}, or restoring divide with remainder in hi, quotient into lo
  assign mul_r  = op_r <= 5'd13;
  assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, bm} : '0);
  assign trial  = {hi, lo[XLEN-1]} - {1'b0, bm};
  assign fits   = !trial[XLEN];
  assign nxt_hi = mul_r ? sum[XLEN:1] : fits ? trial[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
  assign nxt_lo = mul_r ? {sum[0], lo[XLEN-1:1]} : {lo[XLEN-2:0], fits};
  assign prod   = {nxt_hi, nxt_lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -nxt_lo : nxt_lo;
  assign rem    = neg_r ? -nxt_hi : nxt_hi;
  assign eng_res = op_r == 5'd10 ? prod_s[XLEN-1:0] : mul_r ? prod_s[2*XLEN-1:XLEN] : op_r <= 5'd15 ? quo : rem;
  assign last   = cnt == 6'(XLEN-1);
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end
  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? (quick ? DONE : CALC) : IDLE;
      CALC:    state_nxt = last ? DONE : CALC;
      DONE:    state_nxt = bus.out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // handshake outputs decoded from state
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
    bus.busy      = state != IDLE;
    bus.result    = result_r;
    bus.illegal   = illegal_r;
  end
  // operand capture at accept, engine iteration, result/illegal hold until handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= '0;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      bm        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      result_r  <= '0;
      illegal_r <= 1'b0;
    end else if (accept) begin
      op_r      <= op;
      cnt       <= '0;
      hi        <= '0;
      lo        <= op <= 5'd13 ? mb : ma;
      bm        <= op <= 5'd13 ? ma : mb;
      neg_q     <= sa ^ sb;
      neg_r     <= sa;
      illegal_r <= bad;
      if (quick) result_r <= quick_res;
    end else if (state == CALC) begin
      hi  <= nxt_hi;
      lo  <= nxt_lo;
      cnt <= cnt + 6'd1;
      if (last) result_r <= eng_res;
    end else if (state == DONE && bus.out_ready) begin
      illegal_r <= 1'b0;
    end
  end
endmodule
